// File: rtl/timer_periph.sv
// Memory-mapped machine timer: prescaled 64-bit mtime, 64-bit mtimecmp, sticky MATCH, level IRQ.
// Optional macro TIMER_SNAPSHOT_EN: MTIME_HI shadow latched on MTIME_LO reads.
module timer_periph #(
  parameter int unsigned PRESCALE_W = 8,
  parameter logic [63:0] CMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_timer_n,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] write_data,
  output logic [31:0] read_data_timer,
  output logic        timer_irq
);

  typedef enum logic [2:0] {
    A_CTRL        = 3'd0,
    A_STATUS      = 3'd1,
    A_MTIME_LO    = 3'd2,
    A_MTIME_HI    = 3'd3,
    A_MTIMECMP_LO = 3'd4,
    A_MTIMECMP_HI = 3'd5
  } reg_addr_e;

  logic                  ctrl_en;
  logic                  ctrl_irq_en;
  logic [PRESCALE_W-1:0] ctrl_prescale;
  logic [PRESCALE_W-1:0] prescale_new;
  logic [PRESCALE_W-1:0] pcnt;
  logic                  match;
  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic                  wr_en;
  logic                  rd_en;
  logic                  tick;
  logic                  cmp_hit;
  logic [31:0]           mtime_hi_merged;
  logic [31:0]           mtime_lo_inc;

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

  assign wr_en           = ~cs_timer_n & we;
  assign rd_en           = ~cs_timer_n & ~we;
  assign tick            = ctrl_en && (pcnt == ctrl_prescale);
  assign cmp_hit         = (mtime >= mtimecmp);
  assign mtime_hi_merged = merge(mtime[63:32], write_data, wstrb);
  assign mtime_lo_inc    = mtime[31:0] + {31'd0, tick};

  // PRESCALE lives at CTRL[8 +: PRESCALE_W]; each bit follows the strobe of its own byte.
  always_comb begin
    prescale_new = ctrl_prescale;
    for (int unsigned i = 0; i < PRESCALE_W; i++)
      if (wstrb[(8 + i) / 8]) prescale_new[i] = write_data[8 + i];
  end

`ifdef TIMER_SNAPSHOT_EN
  logic [31:0] mtime_hi_shadow;

  always_ff @(posedge clk) begin
    if (rst)
      mtime_hi_shadow <= '0;
    else if (wr_en && addr == A_MTIME_HI)
      mtime_hi_shadow <= mtime_hi_merged;
    else if (rd_en && addr == A_MTIME_LO)
      mtime_hi_shadow <= mtime[63:32];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en       <= 1'b0;
      ctrl_irq_en   <= 1'b0;
      ctrl_prescale <= '0;
      pcnt          <= '0;
      match         <= 1'b0;
      mtime         <= '0;
      mtimecmp      <= CMP_RST;
      timer_irq     <= 1'b0;
    end else begin
      if (wr_en && addr == A_CTRL) begin
        if (wstrb[0]) begin
          ctrl_en     <= write_data[0];
          ctrl_irq_en <= write_data[1];
        end
        ctrl_prescale <= prescale_new;
        pcnt          <= '0;
      end else if (ctrl_en) begin
        pcnt <= tick ? '0 : pcnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
      end

      // A half-word write overrides the tick on that half; HI writes drop the LO carry.
      if (wr_en && addr == A_MTIME_LO)
        mtime[31:0] <= merge(mtime[31:0], write_data, wstrb);
      else if (wr_en && addr == A_MTIME_HI) begin
        mtime[63:32] <= mtime_hi_merged;
        mtime[31:0]  <= mtime_lo_inc;
      end else
        mtime <= mtime + {63'd0, tick};

      if (wr_en && addr == A_MTIMECMP_LO)
        mtimecmp[31:0] <= merge(mtimecmp[31:0], write_data, wstrb);
      if (wr_en && addr == A_MTIMECMP_HI)
        mtimecmp[63:32] <= merge(mtimecmp[63:32], write_data, wstrb);

      if (cmp_hit)
        match <= 1'b1;
      else if (wr_en && addr == A_STATUS && wstrb[0] && write_data[0])
        match <= 1'b0;

      timer_irq <= ctrl_irq_en & cmp_hit;
    end
  end

  always_comb begin
    read_data_timer = '0;
    if (rd_en) begin
      case (addr)
        A_CTRL: begin
          read_data_timer[0]                = ctrl_en;
          read_data_timer[1]                = ctrl_irq_en;
          read_data_timer[8 +: PRESCALE_W]  = ctrl_prescale;
        end
        A_STATUS:      read_data_timer[0] = match;
        A_MTIME_LO:    read_data_timer = mtime[31:0];
`ifdef TIMER_SNAPSHOT_EN
        A_MTIME_HI:    read_data_timer = mtime_hi_shadow;
`else
        A_MTIME_HI:    read_data_timer = mtime[63:32];
`endif
        A_MTIMECMP_LO: read_data_timer = mtimecmp[31:0];
        A_MTIMECMP_HI: read_data_timer = mtimecmp[63:32];
        default:       read_data_timer = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_periph.sv
// Directed bench for timer_periph: reset map, prescaler, carry, compare/IRQ, W1C, byte strobes, reset.
module tb_timer_periph;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_timer_n;
  logic        we;
  logic [2:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] write_data;
  logic [31:0] read_data_timer;
  logic        timer_irq;

  int unsigned checks = 0;
  int unsigned errors = 0;

  timer_periph #(.PRESCALE_W(8), .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .clk             (clk),
    .rst             (rst),
    .cs_timer_n      (cs_timer_n),
    .we              (we),
    .addr            (addr),
    .wstrb           (wstrb),
    .write_data      (write_data),
    .read_data_timer (read_data_timer),
    .timer_irq       (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write commits on the posedge between the two negedges.
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    cs_timer_n = 1'b0; we = 1'b1; addr = a; write_data = d; wstrb = s;
    @(negedge clk);
    cs_timer_n = 1'b1; we = 1'b0; wstrb = 4'h0; write_data = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    cs_timer_n = 1'b0; we = 1'b0; addr = a;
    #1 chk(tag, read_data_timer, exp);
  endtask

  logic [31:0] rst_exp [8];

  initial begin
    rst = 1'b1; cs_timer_n = 1'b1; we = 1'b0; addr = '0; wstrb = '0; write_data = '0;
    rst_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset register map
    #1 chk("deselected_read", read_data_timer, 32'h0);
    chk("irq_reset", {31'd0, timer_irq}, 32'h0);
    for (int i = 0; i < 8; i++) rd($sformatf("reset_off%0d", i), 3'(i), rst_exp[i]);

    // Prescale 3: mtime increments at every 4th edge after enable
    wr(3'd0, 32'h0000_0301, 4'hF);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      cs_timer_n = 1'b0; we = 1'b0; addr = 3'd2;
      #1 chk($sformatf("prescale_cyc%0d", i), read_data_timer, 32'(i / 4));
    end
    wr(3'd0, 32'h0000_0300, 4'h1);
    repeat (10) @(negedge clk);
    rd("frozen_lo", 3'd2, 32'd10);
    rd("ctrl_prescale", 3'd0, 32'h0000_0300);

    // Carry from LO into HI at prescale 0
    wr(3'd2, 32'hFFFF_FFFE, 4'hF);
    wr(3'd3, 32'h0, 4'hF);
    wr(3'd0, 32'h0000_0001, 4'h3);
    rd("carry_lo_pre", 3'd2, 32'hFFFF_FFFF);
`ifdef TIMER_SNAPSHOT_EN
    rd("carry_hi_snap", 3'd3, 32'h0);
`else
    rd("carry_hi_live", 3'd3, 32'h1);
`endif
    rd("carry_lo_post", 3'd2, 32'h1);
    wr(3'd0, 32'h0, 4'h3);
    rd("carry_hi_final", 3'd3, 32'h1);
    rd("carry_lo_final", 3'd2, 32'h3);

    // Compare at 20 with IRQ enabled
    wr(3'd2, 32'h0, 4'hF);
    wr(3'd3, 32'h0, 4'hF);
    wr(3'd4, 32'd20, 4'hF);
    wr(3'd5, 32'h0, 4'hF);
    wr(3'd0, 32'h0000_0003, 4'h3);
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      cs_timer_n = 1'b0; we = 1'b0; addr = 3'd1;
      #1 chk($sformatf("match_cyc%0d", i), read_data_timer, (i == 21) ? 32'h1 : 32'h0);
      chk($sformatf("irq_cyc%0d", i), {31'd0, timer_irq}, (i == 21) ? 32'h1 : 32'h0);
    end
    wr(3'd4, 32'd100, 4'hF);
    #1 chk("irq_after_raise_same", {31'd0, timer_irq}, 32'h1);
    rd("match_sticky", 3'd1, 32'h1);
    chk("irq_after_raise_next", {31'd0, timer_irq}, 32'h0);
    wr(3'd0, 32'h0000_0002, 4'h1);
    wr(3'd1, 32'h0000_0001, 4'h1);
    rd("match_w1c", 3'd1, 32'h0);

    // W1C while compare still hits: set wins
    wr(3'd4, 32'h0, 4'hF);
    wr(3'd1, 32'h0000_0001, 4'h1);
    rd("match_w1c_collide", 3'd1, 32'h1);
    chk("irq_collide", {31'd0, timer_irq}, 32'h1);

    // Byte strobes, unused offset
    wr(3'd4, 32'h1122_3344, 4'hF);
    wr(3'd4, 32'h0000_AB00, 4'b0010);
    rd("cmp_lo_bytes", 3'd4, 32'h1122_AB44);
    rd("cmp_hi", 3'd5, 32'h0);
    wr(3'd6, 32'hDEAD_BEEF, 4'hF);
    rd("off6_ignored", 3'd6, 32'h0);
    rd("ctrl_readback", 3'd0, 32'h0000_0002);

    // Reset mid-count with IRQ asserted
    wr(3'd4, 32'd5, 4'hF);
    wr(3'd0, 32'h0000_0303, 4'h3);
    repeat (3) @(negedge clk);
    #1 chk("irq_before_rst", {31'd0, timer_irq}, 32'h1);
    @(negedge clk);
    cs_timer_n = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("irq_after_rst", {31'd0, timer_irq}, 32'h0);
    for (int i = 0; i < 8; i++) rd($sformatf("rst2_off%0d", i), 3'(i), rst_exp[i]);
    repeat (10) @(negedge clk);
    rd("rst2_stopped", 3'd2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
